// File: rtl/vending_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vending_pkg                                                          |
// | Coin encoding, unit values and change-dispenser state/error codes.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vending_pkg;

   localparam logic [1:0] c_COIN_500  = 2'b00;
   localparam logic [1:0] c_COIN_1000 = 2'b01;
   localparam logic [1:0] c_COIN_2000 = 2'b10;
   localparam logic [1:0] c_COIN_5000 = 2'b11;

   localparam logic [15:0] c_VAL_500  = 16'd5;
   localparam logic [15:0] c_VAL_1000 = 16'd10;
   localparam logic [15:0] c_VAL_2000 = 16'd20;
   localparam logic [15:0] c_VAL_5000 = 16'd50;

   localparam logic c_ERR_UNDERPAID = 1'b0;
   localparam logic c_ERR_NO_CHANGE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CALC = 3'd1,
      ST_EMIT = 3'd2,
      ST_DONE = 3'd3,
      ST_FAIL = 3'd4
   } change_state_t;

   function automatic logic [15:0] coin_value(input logic [1:0] code);
      case (code)
         c_COIN_500:  coin_value = c_VAL_500;
         c_COIN_1000: coin_value = c_VAL_1000;
         c_COIN_2000: coin_value = c_VAL_2000;
         default:     coin_value = c_VAL_5000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_stock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coin_stock                                                           |
// | Saturating 8-bit float counter for one coin denomination.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coin_stock #(
   parameter logic [7:0] INIT_COUNT = 8'd4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] count,
   output logic       nonzero
);

   logic [7:0] r_count;

   // Simultaneous inc and dec cancel out.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= INIT_COUNT;
      end else if (inc && !dec) begin
         if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end else if (dec && !inc) begin
         if (r_count != 8'h00) r_count <= r_count - 8'd1;
      end
   end

   assign count   = r_count;
   assign nonzero = (r_count != 8'h00);

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | change_dispenser                                                     |
// | Greedy coin-by-coin change release with a replenishable float.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module change_dispenser
   import vending_pkg::*;
#(
   parameter logic [7:0] INIT_STOCK = 8'd4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] paid_total,
   input  logic [15:0] cost,
   input  logic        coin_in_valid,
   input  logic [1:0]  coin_in_type,
   input  logic        coin_ready,
   output logic        coin_valid,
   output logic [1:0]  coin_type,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        error_code,
   output logic [15:0] remaining,
   output logic [7:0]  stock_500,
   output logic [7:0]  stock_1000,
   output logic [7:0]  stock_2000,
   output logic [7:0]  stock_5000
);

   change_state_t r_state;
   change_state_t w_next_state;

   logic [15:0] r_remaining;
   logic [1:0]  r_coin_type;
   logic        r_err_code;

   logic [3:0]  w_inc;
   logic [3:0]  w_dec;
   logic [3:0]  w_nonzero;
   logic [7:0]  w_count [4];

   logic        w_handshake;
   logic        w_pick_valid;
   logic [1:0]  w_pick;

   assign w_handshake = (r_state == ST_EMIT) && coin_ready;

   for (genvar g = 0; g < 4; g++) begin : g_stock
      assign w_inc[g] = coin_in_valid && (coin_in_type == 2'(g));
      assign w_dec[g] = w_handshake && (r_coin_type == 2'(g));

      coin_stock #(
         .INIT_COUNT (INIT_STOCK)
      ) u_stock (
         .clock   (clock),
         .reset   (reset),
         .inc     (w_inc[g]),
         .dec     (w_dec[g]),
         .count   (w_count[g]),
         .nonzero (w_nonzero[g])
      );
   end

   // Codes ascend with value, so the last qualifying index is the largest coin.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick       = c_COIN_500;
      for (int i = 0; i < 4; i++) begin
         if (w_nonzero[i] && (coin_value(2'(i)) <= r_remaining)) begin
            w_pick_valid = 1'b1;
            w_pick       = 2'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = (cost > paid_total) ? ST_FAIL : ST_CALC;
         end
         ST_CALC: begin
            if (r_remaining == 16'd0) w_next_state = ST_DONE;
            else if (w_pick_valid)    w_next_state = ST_EMIT;
            else                      w_next_state = ST_FAIL;
         end
         ST_EMIT: begin
            if (coin_ready) w_next_state = ST_CALC;
         end
         ST_DONE: w_next_state = ST_IDLE;
         ST_FAIL: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_remaining <= 16'd0;
         r_coin_type <= c_COIN_500;
         r_err_code  <= c_ERR_UNDERPAID;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (cost > paid_total) r_err_code  <= c_ERR_UNDERPAID;
                  else                   r_remaining <= paid_total - cost;
               end
            end
            ST_CALC: begin
               if (r_remaining != 16'd0) begin
                  if (w_pick_valid) r_coin_type <= w_pick;
                  else              r_err_code  <= c_ERR_NO_CHANGE;
               end
            end
            ST_EMIT: begin
               if (coin_ready) r_remaining <= r_remaining - coin_value(r_coin_type);
            end
            default: ;
         endcase
      end
   end

   assign coin_valid = (r_state == ST_EMIT);
   assign coin_type  = r_coin_type;
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign error      = (r_state == ST_FAIL);
   assign error_code = r_err_code;
   assign remaining  = r_remaining;

   assign stock_500  = w_count[0];
   assign stock_1000 = w_count[1];
   assign stock_2000 = w_count[2];
   assign stock_5000 = w_count[3];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_change_dispenser                                                  |
// | Directed bench with a coin scoreboard for two float sizes.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_change_dispenser;

   logic        clock;
   logic        reset;
   logic        start4;
   logic        start1;
   logic [15:0] paid_total;
   logic [15:0] cost;
   logic        coin_in_valid;
   logic [1:0]  coin_in_type;
   logic        coin_ready;

   logic        a_coin_valid, a_busy, a_done, a_error, a_error_code;
   logic [1:0]  a_coin_type;
   logic [15:0] a_remaining;
   logic [7:0]  a_s500, a_s1000, a_s2000, a_s5000;

   logic        b_coin_valid, b_busy, b_done, b_error, b_error_code;
   logic [1:0]  b_coin_type;
   logic [15:0] b_remaining;
   logic [7:0]  b_s500, b_s1000, b_s2000, b_s5000;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  q4 [$];
   logic [1:0]  q1 [$];

   change_dispenser #(.INIT_STOCK(8'd4)) dut4 (
      .clock(clock), .reset(reset), .start(start4),
      .paid_total(paid_total), .cost(cost),
      .coin_in_valid(coin_in_valid), .coin_in_type(coin_in_type),
      .coin_ready(coin_ready), .coin_valid(a_coin_valid), .coin_type(a_coin_type),
      .busy(a_busy), .done(a_done), .error(a_error), .error_code(a_error_code),
      .remaining(a_remaining), .stock_500(a_s500), .stock_1000(a_s1000),
      .stock_2000(a_s2000), .stock_5000(a_s5000)
   );

   change_dispenser #(.INIT_STOCK(8'd1)) dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .paid_total(paid_total), .cost(cost),
      .coin_in_valid(coin_in_valid), .coin_in_type(coin_in_type),
      .coin_ready(coin_ready), .coin_valid(b_coin_valid), .coin_type(b_coin_type),
      .busy(b_busy), .done(b_done), .error(b_error), .error_code(b_error_code),
      .remaining(b_remaining), .stock_500(b_s500), .stock_1000(b_s1000),
      .stock_2000(b_s2000), .stock_5000(b_s5000)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic launch4(input logic [15:0] p, input logic [15:0] c);
      paid_total = p;
      cost       = c;
      start4     = 1'b1;
      tick();
      start4     = 1'b0;
   endtask

   // Coins are popped in the middle of the low phase, after inputs settle.
   always @(negedge clock) begin
      #2;
      if (!reset && a_coin_valid && coin_ready) begin
         if (q4.size() == 0) begin
            n_tests++;
            assert (0) else begin
               n_fail++;
               $error("FAIL coin4_unexpected observed=%0d expected=none", a_coin_type);
            end
         end else begin
            check("coin4_type", 32'(a_coin_type), 32'(q4.pop_front()));
         end
      end
      if (!reset && b_coin_valid && coin_ready) begin
         if (q1.size() == 0) begin
            n_tests++;
            assert (0) else begin
               n_fail++;
               $error("FAIL coin1_unexpected observed=%0d expected=none", b_coin_type);
            end
         end else begin
            check("coin1_type", 32'(b_coin_type), 32'(q1.pop_front()));
         end
      end
   end

   initial begin
      int cyc;
      clock = 1'b0; reset = 1'b1; start4 = 1'b0; start1 = 1'b0;
      paid_total = 16'd0; cost = 16'd0;
      coin_in_valid = 1'b0; coin_in_type = 2'b00; coin_ready = 1'b1;
      tick(); tick();

      check("rst_busy",       32'(a_busy), 0);
      check("rst_coin_valid", 32'(a_coin_valid), 0);
      check("rst_done",       32'(a_done), 0);
      check("rst_error",      32'(a_error), 0);
      check("rst_error_code", 32'(a_error_code), 0);
      check("rst_coin_type",  32'(a_coin_type), 0);
      check("rst_remaining",  32'(a_remaining), 0);
      check("rst_s500",       32'(a_s500), 4);
      check("rst_s5000",      32'(a_s5000), 4);
      check("rst_b_s2000",    32'(b_s2000), 1);
      reset = 1'b0;
      tick();

      // Underpayment
      launch4(16'd20, 16'd25);
      check("under_error",      32'(a_error), 1);
      check("under_error_code", 32'(a_error_code), 0);
      check("under_coin_valid", 32'(a_coin_valid), 0);
      check("under_busy",       32'(a_busy), 1);
      tick();
      check("under_error_end",  32'(a_error), 0);
      check("under_idle",       32'(a_busy), 0);
      check("under_s500",  32'(a_s500), 4);
      check("under_s1000", 32'(a_s1000), 4);
      check("under_s2000", 32'(a_s2000), 4);
      check("under_s5000", 32'(a_s5000), 4);

      // Change 75 with ready held high
      q4.push_back(2'b11); q4.push_back(2'b10); q4.push_back(2'b00);
      launch4(16'd90, 16'd15);
      check("c75_busy_t1",  32'(a_busy), 1);
      check("c75_valid_t1", 32'(a_coin_valid), 0);
      tick();
      check("c75_valid_t2", 32'(a_coin_valid), 1);
      check("c75_type_t2",  32'(a_coin_type), 3);
      check("c75_rem_t2",   32'(a_remaining), 75);
      cyc = 2;
      while (!a_done && cyc < 30) begin
         tick();
         cyc++;
      end
      check("c75_done_cycle", 32'(cyc), 8);
      check("c75_rem",   32'(a_remaining), 0);
      check("c75_s500",  32'(a_s500), 3);
      check("c75_s1000", 32'(a_s1000), 4);
      check("c75_s2000", 32'(a_s2000), 3);
      check("c75_s5000", 32'(a_s5000), 3);
      tick();

      // Exact payment
      launch4(16'd30, 16'd30);
      check("exact_done_t1", 32'(a_done), 0);
      tick();
      check("exact_done_t2",  32'(a_done), 1);
      check("exact_valid_t2", 32'(a_coin_valid), 0);
      tick();
      check("exact_done_end", 32'(a_done), 0);
      check("exact_idle",     32'(a_busy), 0);

      // Backpressure on a single 500 coin
      coin_ready = 1'b0;
      launch4(16'd10, 16'd5);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("bp_valid", 32'(a_coin_valid), 1);
         check("bp_type",  32'(a_coin_type), 0);
         check("bp_rem",   32'(a_remaining), 5);
         check("bp_s500",  32'(a_s500), 3);
         tick();
      end
      q4.push_back(2'b00);
      coin_ready = 1'b1;
      tick();
      check("bp_s500_after", 32'(a_s500), 2);
      check("bp_rem_after",  32'(a_remaining), 0);
      check("bp_valid_after", 32'(a_coin_valid), 0);
      tick();
      check("bp_done", 32'(a_done), 1);
      tick();

      // Thin float: change 40 runs out at 5
      q1.push_back(2'b10); q1.push_back(2'b01); q1.push_back(2'b00);
      paid_total = 16'd50; cost = 16'd10; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cyc = 1;
      while (!b_error && cyc < 30) begin
         tick();
         cyc++;
      end
      check("thin_error_cycle", 32'(cyc), 8);
      check("thin_error_code",  32'(b_error_code), 1);
      check("thin_rem",   32'(b_remaining), 5);
      check("thin_s500",  32'(b_s500), 0);
      check("thin_s1000", 32'(b_s1000), 0);
      check("thin_s2000", 32'(b_s2000), 0);
      check("thin_s5000", 32'(b_s5000), 1);
      tick();
      check("thin_idle", 32'(b_busy), 0);

      // Plain deposit, then deposit coinciding with a release of the same type
      coin_in_valid = 1'b1; coin_in_type = 2'b01;
      tick();
      coin_in_valid = 1'b0;
      check("dep_s1000", 32'(a_s1000), 5);
      q4.push_back(2'b11);
      launch4(16'd60, 16'd10);
      tick();
      check("same_valid", 32'(a_coin_valid), 1);
      coin_in_valid = 1'b1; coin_in_type = 2'b11;
      tick();
      coin_in_valid = 1'b0;
      check("same_s5000", 32'(a_s5000), 3);
      check("same_rem",   32'(a_remaining), 0);
      tick();
      check("same_done", 32'(a_done), 1);
      tick();

      // Saturation
      coin_in_valid = 1'b1; coin_in_type = 2'b00;
      for (int k = 0; k < 300; k++) tick();
      coin_in_valid = 1'b0;
      check("sat_s500",  32'(a_s500), 255);
      check("sat_s1000", 32'(a_s1000), 5);

      // Reset in EMIT
      coin_ready = 1'b0;
      launch4(16'd100, 16'd0);
      tick();
      check("rmid_valid", 32'(a_coin_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmid_busy",  32'(a_busy), 0);
      check("rmid_valid_after", 32'(a_coin_valid), 0);
      check("rmid_rem",   32'(a_remaining), 0);
      check("rmid_s500",  32'(a_s500), 4);
      check("rmid_s1000", 32'(a_s1000), 4);
      check("rmid_s5000", 32'(a_s5000), 4);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rmid_no_done",  32'(a_done), 0);
         check("rmid_no_error", 32'(a_error), 0);
      end
      coin_ready = 1'b1;
      tick();

      check("q4_drained", 32'(q4.size()), 0);
      check("q1_drained", 32'(q1.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
